// File: rtl/decode_div_pkg.sv
// Shared constants and types for the decode-path sequential divider.
// Widths mirror the forward product path (40s x 21u -> 60s).
package decode_div_pkg;

  localparam int DIN0_WIDTH = 60;
  localparam int DIN1_WIDTH = 21;
  localparam int DOUT_WIDTH = 40;
  localparam int CNT_WIDTH  = $clog2(DIN0_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    POST
  } div_state_t;

  localparam logic signed [DOUT_WIDTH-1:0] Q_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] Q_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/decode_div_sat.sv
// Applies the quotient sign to an unsigned magnitude and clips the result
// to the signed output range, flagging any clipping.
module decode_div_sat
  import decode_div_pkg::*;
(
  input  logic [DIN0_WIDTH-1:0]        mag,
  input  logic                         neg,
  output logic signed [DOUT_WIDTH-1:0] q,
  output logic                         ovf
);

  localparam logic [DIN0_WIDTH-1:0] POS_LIM = {{(DIN0_WIDTH-DOUT_WIDTH){1'b0}}, Q_MAX};
  // Negative side reaches one further: magnitude 2^(DOUT_WIDTH-1) is still representable.
  localparam logic [DIN0_WIDTH-1:0] NEG_LIM = POS_LIM + DIN0_WIDTH'(1);

  always_comb begin
    q   = '0;
    ovf = 1'b0;
    if (neg) begin
      if (mag > NEG_LIM) begin
        q   = Q_MIN;
        ovf = 1'b1;
      end else begin
        q = -mag[DOUT_WIDTH-1:0];
      end
    end else begin
      if (mag > POS_LIM) begin
        q   = Q_MAX;
        ovf = 1'b1;
      end else begin
        q = mag[DOUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/decode_div_60s_21ns_40_seq.sv
// Radix-2 restoring divider: signed 60-bit dividend by unsigned 21-bit divisor,
// one quotient bit per enabled cycle, saturated signed 40-bit quotient.
module decode_div_60s_21ns_40_seq
  import decode_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [DIN1_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  dbz
);

  div_state_t            state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  // Holds the dividend magnitude; quotient bits shift in from the bottom as it drains.
  logic [DIN0_WIDTH-1:0] work_reg;
  logic [DIN1_WIDTH:0]   pr_reg;
  logic [DIN1_WIDTH-1:0] divisor_reg;
  logic                  neg_reg;
  logic                  done_reg, ovf_reg, dbz_reg;
  logic [DOUT_WIDTH-1:0] dout_reg;
  logic [DIN1_WIDTH:0]   rem_reg;

  logic [DIN1_WIDTH:0]          trial, pr_step;
  logic                         fits;
  logic signed [DOUT_WIDTH-1:0] sat_q;
  logic                         sat_ovf;
  logic [DIN1_WIDTH:0]          rem_fix;

  // pr_reg stays below the divisor, so its top bit is always zero entering a step.
  assign trial   = {pr_reg[DIN1_WIDTH-1:0], work_reg[DIN0_WIDTH-1]};
  assign fits    = trial >= {1'b0, divisor_reg};
  assign pr_step = fits ? (trial - {1'b0, divisor_reg}) : trial;
  assign rem_fix = neg_reg ? -pr_reg : pr_reg;

  decode_div_sat u_sat (
    .mag (work_reg),
    .neg (neg_reg),
    .q   (sat_q),
    .ovf (sat_ovf)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt_reg == CNT_WIDTH'(1)) state_next = POST;
      POST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      pr_reg      <= '0;
      divisor_reg <= '0;
      neg_reg     <= 1'b0;
      done_reg    <= 1'b0;
      dout_reg    <= '0;
      rem_reg     <= '0;
      ovf_reg     <= 1'b0;
      dbz_reg     <= 1'b0;
    end else if (ce) begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            work_reg    <= din0[DIN0_WIDTH-1] ? -din0 : din0;
            neg_reg     <= din0[DIN0_WIDTH-1];
            divisor_reg <= din1;
            pr_reg      <= '0;
            cnt_reg     <= CNT_WIDTH'(DIN0_WIDTH);
          end
        end
        CALC: begin
          work_reg <= {work_reg[DIN0_WIDTH-2:0], fits};
          pr_reg   <= pr_step;
          cnt_reg  <= cnt_reg - CNT_WIDTH'(1);
        end
        POST: begin
          done_reg <= 1'b1;
          if (divisor_reg == '0) begin
            dout_reg <= neg_reg ? Q_MIN : Q_MAX;
            rem_reg  <= '0;
            ovf_reg  <= 1'b0;
            dbz_reg  <= 1'b1;
          end else begin
            dout_reg <= sat_q;
            rem_reg  <= rem_fix;
            ovf_reg  <= sat_ovf;
            dbz_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_reg == IDLE);
  assign done  = done_reg;
  assign dout  = dout_reg;
  assign rem   = rem_reg;
  assign ovf   = ovf_reg;
  assign dbz   = dbz_reg;

endmodule

// File: tb/tb_decode_div_60s_21ns_40_seq.sv
// Directed bench for the sequential decode divider: arithmetic table,
// busy-start rejection, clock-enable stalls, back-to-back and mid-op reset.
module tb_decode_div_60s_21ns_40_seq;

  logic        clk = 1'b0;
  logic        reset, ce, start;
  logic [59:0] din0;
  logic [20:0] din1;
  logic        ready, done, ovf, dbz;
  logic [39:0] dout;
  logic [21:0] rem;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [39:0] q_c;
  logic [21:0] r_c;
  logic        ovf_c, dbz_c;
  int          lat_c;

  localparam logic [39:0] QMAX = 40'h7F_FFFF_FFFF;
  localparam logic [39:0] QMIN = 40'h80_0000_0000;
  localparam int          LAT  = 61;

  typedef struct packed {
    logic [59:0] a;
    logic [20:0] b;
    logic [39:0] q;
    logic [21:0] r;
    logic        o;
    logic        z;
  } vec_t;

  always #5 clk = ~clk;

  decode_div_60s_21ns_40_seq dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .ready (ready),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  task automatic launch(input logic [59:0] a, input logic [20:0] b);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; optional busy start and ce stall.
  task automatic wait_done(input int glitch_at, input int ce_lo, input int ce_len);
    lat_c = 0;
    while (done !== 1'b1 && lat_c < 300) begin
      start = (lat_c == glitch_at);
      if (lat_c == glitch_at) begin
        din0 = 60'd999;
        din1 = 21'd1;
      end
      ce = !(lat_c >= ce_lo && lat_c < ce_lo + ce_len);
      @(negedge clk);
      lat_c++;
    end
    start = 1'b0;
    ce    = 1'b1;
    q_c   = dout;
    r_c   = rem;
    ovf_c = ovf;
    dbz_c = dbz;
    $display("div dout=%0d rem=%0d ovf=%0b dbz=%0b latency=%0d",
             $signed(q_c), $signed(r_c), ovf_c, dbz_c, lat_c);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt += 6;
    if (ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", ready); else pass_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
    if (dout !== 40'd0) $display("FAIL reset_dout got=%h want=0", dout); else pass_cnt++;
    if (rem !== 22'd0) $display("FAIL reset_rem got=%h want=0", rem); else pass_cnt++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b want=0", ovf); else pass_cnt++;
    if (dbz !== 1'b0) $display("FAIL reset_dbz got=%b want=0", dbz); else pass_cnt++;
  endtask

  task automatic test_arith();
    vec_t vecs[11];
    vecs[0]  = '{60'd100, 21'd7, 40'd14, 22'd2, 1'b0, 1'b0};
    vecs[1]  = '{-60'sd100, 21'd7, -40'sd14, -22'sd2, 1'b0, 1'b0};
    vecs[2]  = '{-60'sd6, 21'd3, -40'sd2, 22'd0, 1'b0, 1'b0};
    vecs[3]  = '{60'd5, 21'd0, QMAX, 22'd0, 1'b0, 1'b1};
    vecs[4]  = '{-60'sd5, 21'd0, QMIN, 22'd0, 1'b0, 1'b1};
    vecs[5]  = '{60'h800_0000_0000_0000, 21'd1, QMIN, 22'd0, 1'b1, 1'b0};
    vecs[6]  = '{60'h7FF_FFFF_FFFF_FFFF, 21'h1F_FFFF, 40'h40_0002_0000, 22'd131071, 1'b0, 1'b0};
    vecs[7]  = '{60'h80_0000_0000, 21'd1, QMAX, 22'd0, 1'b1, 1'b0};
    vecs[8]  = '{60'hFFF_FF80_0000_0000, 21'd1, QMIN, 22'd0, 1'b0, 1'b0};
    vecs[9]  = '{60'd0, 21'd5, 40'd0, 22'd0, 1'b0, 1'b0};
    vecs[10] = '{60'd1000000007, 21'd1000, 40'd1000000, 22'd7, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(-1, -1, 0);
      total_cnt += 5;
      if (lat_c != LAT) $display("FAIL arith%0d_latency got=%0d want=%0d", i, lat_c, LAT); else pass_cnt++;
      if (q_c !== vecs[i].q) $display("FAIL arith%0d_dout got=%h want=%h", i, q_c, vecs[i].q); else pass_cnt++;
      if (r_c !== vecs[i].r) $display("FAIL arith%0d_rem got=%h want=%h", i, r_c, vecs[i].r); else pass_cnt++;
      if (ovf_c !== vecs[i].o) $display("FAIL arith%0d_ovf got=%b want=%b", i, ovf_c, vecs[i].o); else pass_cnt++;
      if (dbz_c !== vecs[i].z) $display("FAIL arith%0d_dbz got=%b want=%b", i, dbz_c, vecs[i].z); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    launch(60'd100, 21'd7);
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL busy_ready got=%b want=0", ready); else pass_cnt++;
    wait_done(10, -1, 0);
    total_cnt += 3;
    if (lat_c != LAT) $display("FAIL ignore_latency got=%0d want=%0d", lat_c, LAT); else pass_cnt++;
    if (q_c !== 40'd14) $display("FAIL ignore_dout got=%0d want=14", q_c); else pass_cnt++;
    if (r_c !== 22'd2) $display("FAIL ignore_rem got=%0d want=2", r_c); else pass_cnt++;
    // The rejected start must not have queued a second operation.
    repeat (70) @(negedge clk);
    total_cnt++;
    if (ready !== 1'b1 || done !== 1'b0 || dout !== 40'd14)
      $display("FAIL ignore_noqueue got ready=%b done=%b dout=%0d want ready=1 done=0 dout=14",
               ready, done, dout);
    else pass_cnt++;
  endtask

  task automatic test_ce_stall();
    launch(-60'sd100, 21'd7);
    wait_done(-1, 10, 10);
    total_cnt += 3;
    if (lat_c != LAT + 10) $display("FAIL stall_latency got=%0d want=%0d", lat_c, LAT + 10); else pass_cnt++;
    if (q_c !== -40'sd14) $display("FAIL stall_dout got=%h want=%h", q_c, -40'sd14); else pass_cnt++;
    if (r_c !== -22'sd2) $display("FAIL stall_rem got=%h want=%h", r_c, -22'sd2); else pass_cnt++;
    ce = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL stall_done_held got=%b want=1", done); else pass_cnt++;
    ce = 1'b1;
    @(negedge clk);
    total_cnt += 2;
    if (done !== 1'b0) $display("FAIL stall_done_drop got=%b want=0", done); else pass_cnt++;
    if (dout !== -40'sd14) $display("FAIL stall_dout_held got=%h want=%h", dout, -40'sd14); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    launch(60'd100, 21'd7);
    wait_done(-1, -1, 0);
    total_cnt += 2;
    if (lat_c != LAT) $display("FAIL b2b_first_latency got=%0d want=%0d", lat_c, LAT); else pass_cnt++;
    if (ready !== 1'b1) $display("FAIL b2b_ready_in_done got=%b want=1", ready); else pass_cnt++;
    launch(60'd1000000007, 21'd1000);
    total_cnt += 2;
    if (done !== 1'b0) $display("FAIL b2b_done_width got=%b want=0", done); else pass_cnt++;
    if (ready !== 1'b0) $display("FAIL b2b_accepted got=%b want=0", ready); else pass_cnt++;
    wait_done(-1, -1, 0);
    total_cnt += 3;
    if (lat_c != LAT) $display("FAIL b2b_second_latency got=%0d want=%0d", lat_c, LAT); else pass_cnt++;
    if (q_c !== 40'd1000000) $display("FAIL b2b_dout got=%0d want=1000000", q_c); else pass_cnt++;
    if (r_c !== 22'd7) $display("FAIL b2b_rem got=%0d want=7", r_c); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_midop_reset();
    int seen;
    launch(60'd100, 21'd7);
    repeat (29) @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt += 6;
    if (ready !== 1'b1) $display("FAIL rst_ready got=%b want=1", ready); else pass_cnt++;
    if (done !== 1'b0) $display("FAIL rst_done got=%b want=0", done); else pass_cnt++;
    if (dout !== 40'd0) $display("FAIL rst_dout got=%h want=0", dout); else pass_cnt++;
    if (rem !== 22'd0) $display("FAIL rst_rem got=%h want=0", rem); else pass_cnt++;
    if (ovf !== 1'b0) $display("FAIL rst_ovf got=%b want=0", ovf); else pass_cnt++;
    if (dbz !== 1'b0) $display("FAIL rst_dbz got=%b want=0", dbz); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL rst_no_done got=%0d want=0", seen); else pass_cnt++;
    launch(-60'sd6, 21'd3);
    wait_done(-1, -1, 0);
    total_cnt += 3;
    if (lat_c != LAT) $display("FAIL rst_after_latency got=%0d want=%0d", lat_c, LAT); else pass_cnt++;
    if (q_c !== -40'sd2) $display("FAIL rst_after_dout got=%h want=%h", q_c, -40'sd2); else pass_cnt++;
    if (r_c !== 22'd0) $display("FAIL rst_after_rem got=%h want=0", r_c); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_arith();
    test_ignore_start();
    test_ce_stall();
    test_back_to_back();
    test_midop_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
